// File: rtl/mem_bank_controller.sv
// Open-page command stage in front of the MemCore array: keeps one row buffered,
// sequences Precharge/Activate with one-hot RowAddress, and serves word accesses.
module mem_bank_controller #(
   parameter int unsigned ROWS     = 256,
   parameter int unsigned ROW_BITS = 8,
   parameter int unsigned WORD     = 32,
   parameter int unsigned COLS     = 64,
   parameter int unsigned COL_BITS = 6,
   parameter int unsigned T_RP     = 2,
   parameter int unsigned T_RCD    = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [ROW_BITS-1:0]    req_row,
   input  logic [COL_BITS-1:0]    req_col,
   input  logic [WORD-1:0]        req_wdata,
   input  logic                   close_req,
   output logic                   rsp_valid,
   output logic [WORD-1:0]        rsp_rdata,
   output logic                   Precharge,
   output logic                   Activate,
   output logic [ROWS-1:0]        RowAddress,
   output logic [COLS*WORD-1:0]   RowBufferIn,
   input  logic [COLS*WORD-1:0]   CoreOut,
   output logic                   row_open,
   output logic [ROW_BITS-1:0]    open_row
);

   localparam int unsigned ROW_W = COLS * WORD;
   localparam int unsigned IDX_W = $clog2(ROW_W);
   localparam int unsigned CNT_W = 8;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] PRE   = 2'd1;
   localparam logic [1:0] ACT   = 2'd2;
   localparam logic [1:0] CLOSE = 2'd3;

   logic [1:0]          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                lat_write_q, lat_write_d;
   logic [ROW_BITS-1:0] lat_row_q, lat_row_d;
   logic [COL_BITS-1:0] lat_col_q, lat_col_d;
   logic [WORD-1:0]     lat_wdata_q, lat_wdata_d;
   logic [ROW_W-1:0]    buf_q, buf_d;
   logic                row_open_q, row_open_d;
   logic [ROW_BITS-1:0] open_row_q, open_row_d;
   logic                pre_q, pre_d;
   logic                act_q, act_d;
   logic [ROWS-1:0]     raddr_q, raddr_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [WORD-1:0]     rsp_rdata_q, rsp_rdata_d;
   logic                accept;
   logic [ROW_W-1:0]    merged;

   function automatic logic [IDX_W-1:0] col_base(input logic [COL_BITS-1:0] col);
      return IDX_W'(col) * IDX_W'(WORD);
   endfunction

   // A pending close on an open row blocks new requests for this cycle.
   assign req_ready = reset && (state_q == IDLE) && !(close_req && row_open_q);
   assign accept    = req_valid && req_ready;

   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign Precharge   = pre_q;
   assign Activate    = act_q;
   assign RowAddress  = raddr_q;
   assign RowBufferIn = buf_q;
   assign row_open    = row_open_q;
   assign open_row    = open_row_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         lat_write_q <= 1'b0;
         lat_row_q   <= '0;
         lat_col_q   <= '0;
         lat_wdata_q <= '0;
         buf_q       <= '0;
         row_open_q  <= 1'b0;
         open_row_q  <= '0;
         pre_q       <= 1'b0;
         act_q       <= 1'b0;
         raddr_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lat_write_q <= lat_write_d;
         lat_row_q   <= lat_row_d;
         lat_col_q   <= lat_col_d;
         lat_wdata_q <= lat_wdata_d;
         buf_q       <= buf_d;
         row_open_q  <= row_open_d;
         open_row_q  <= open_row_d;
         pre_q       <= pre_d;
         act_q       <= act_d;
         raddr_q     <= raddr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lat_write_d = lat_write_q;
      lat_row_d   = lat_row_q;
      lat_col_d   = lat_col_q;
      lat_wdata_d = lat_wdata_q;
      buf_d       = buf_q;
      row_open_d  = row_open_q;
      open_row_d  = open_row_q;
      pre_d       = pre_q;
      act_d       = act_q;
      raddr_d     = raddr_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      merged      = CoreOut;
      if (lat_write_q) merged[col_base(lat_col_q) +: WORD] = lat_wdata_q;

      case (state_q)
         IDLE: begin
            if (close_req && row_open_q) begin
               state_d = CLOSE;
               pre_d   = 1'b1;
               cnt_d   = CNT_W'(T_RP - 1);
            end else if (accept) begin
               lat_write_d = req_write;
               lat_row_d   = req_row;
               lat_col_d   = req_col;
               lat_wdata_d = req_wdata;
               if (32'(req_row) >= ROWS) begin
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = '0;
               end else if (row_open_q && (req_row == open_row_q)) begin
                  rsp_valid_d = 1'b1;
                  if (req_write) begin
                     buf_d[col_base(req_col) +: WORD] = req_wdata;
                     rsp_rdata_d = req_wdata;
                  end else begin
                     rsp_rdata_d = buf_q[col_base(req_col) +: WORD];
                  end
               end else if (row_open_q) begin
                  // RowAddress still selects the open row for the write-back.
                  state_d = PRE;
                  pre_d   = 1'b1;
                  cnt_d   = CNT_W'(T_RP - 1);
               end else begin
                  state_d = ACT;
                  act_d   = 1'b1;
                  raddr_d = ROWS'(1) << req_row;
                  cnt_d   = CNT_W'(T_RCD - 1);
               end
            end
         end
         PRE: begin
            if (cnt_q == '0) begin
               state_d = ACT;
               pre_d   = 1'b0;
               act_d   = 1'b1;
               raddr_d = ROWS'(1) << lat_row_q;
               cnt_d   = CNT_W'(T_RCD - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ACT: begin
            if (cnt_q == '0) begin
               state_d     = IDLE;
               act_d       = 1'b0;
               buf_d       = merged;
               open_row_d  = lat_row_q;
               row_open_d  = 1'b1;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = lat_write_q ? lat_wdata_q : CoreOut[col_base(lat_col_q) +: WORD];
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         CLOSE: begin
            if (cnt_q == '0) begin
               state_d    = IDLE;
               pre_d      = 1'b0;
               row_open_d = 1'b0;
               raddr_d    = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_bank_controller.sv
// Directed bench for mem_bank_controller: reset, hits, closed/open misses and close handling.
module tb_mem_bank_controller;

   logic          clk;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [7:0]    req_row;
   logic [5:0]    req_col;
   logic [31:0]   req_wdata;
   logic          close_req;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          Precharge;
   logic          Activate;
   logic [255:0]  RowAddress;
   logic [2047:0] RowBufferIn;
   logic [2047:0] CoreOut;
   logic          row_open;
   logic [7:0]    open_row;

   int checks = 0;
   int errors = 0;

   mem_bank_controller dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
      .close_req(close_req),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .Precharge(Precharge), .Activate(Activate), .RowAddress(RowAddress),
      .RowBufferIn(RowBufferIn), .CoreOut(CoreOut),
      .row_open(row_open), .open_row(open_row)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Precharge and Activate must never overlap.
   always @(negedge clk) begin
      if (reset) begin
         checks++;
         assert (!(Precharge && Activate)) else begin
            errors++;
            $error("FAIL pre_act_overlap observed=1 expected=0");
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_row = '0; req_col = '0;
      req_wdata = '0; close_req = 1'b0; CoreOut = '0;
      tick(); tick();
      chk1("rst_ready", req_ready, 1'b0);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk32("rst_rdata", rsp_rdata, 32'h0);
      chk1("rst_pre", Precharge, 1'b0);
      chk1("rst_act", Activate, 1'b0);
      chk256("rst_raddr", RowAddress, 256'h0);
      chk1("rst_row_open", row_open, 1'b0);
      reset = 1'b1;
      #1;
      chk1("ready_after_rst", req_ready, 1'b1);

      // reset asserted in the middle of an activate
      req_valid = 1'b1; req_write = 1'b0; req_row = 8'd3; req_col = 6'd0;
      tick();
      req_valid = 1'b0;
      chk1("midact_act_high", Activate, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk1("midact_act_drop", Activate, 1'b0);
      chk1("midact_pre_drop", Precharge, 1'b0);
      chk256("midact_raddr_drop", RowAddress, 256'h0);
      chk1("midact_row_open", row_open, 1'b0);
      @(posedge clk); #1;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk1("midact_no_rsp", rsp_valid, 1'b0);
      end
      chk1("midact_row_closed", row_open, 1'b0);

      // closed miss: read row 2 col 0
      CoreOut = {64{32'hF0F0F0F0}};
      req_valid = 1'b1; req_write = 1'b0; req_row = 8'd2; req_col = 6'd0;
      tick();
      req_valid = 1'b0; req_row = 8'd0;
      chk1("cm_act_n1", Activate, 1'b1);
      chk256("cm_raddr", RowAddress, 256'h4);
      chk1("cm_no_rsp_n1", rsp_valid, 1'b0);
      tick();
      chk1("cm_act_n2", Activate, 1'b1);
      chk1("cm_no_rsp_n2", rsp_valid, 1'b0);
      tick();
      chk1("cm_act_off", Activate, 1'b0);
      chk1("cm_rsp", rsp_valid, 1'b1);
      chk32("cm_rdata", rsp_rdata, 32'hF0F0F0F0);
      chk1("cm_row_open", row_open, 1'b1);
      chk32("cm_open_row", 32'(open_row), 32'd2);
      tick();
      chk1("cm_rsp_pulse", rsp_valid, 1'b0);

      // hits: write col 5, read col 5, read col 1 back-to-back
      CoreOut = '0;
      req_valid = 1'b1; req_write = 1'b1; req_row = 8'd2; req_col = 6'd5; req_wdata = 32'hDEADBEEF;
      tick();
      chk1("hit_w_rsp", rsp_valid, 1'b1);
      chk32("hit_w_rdata", rsp_rdata, 32'hDEADBEEF);
      req_write = 1'b0; req_wdata = 32'h0;
      tick();
      chk1("hit_r_rsp", rsp_valid, 1'b1);
      chk32("hit_r_rdata", rsp_rdata, 32'hDEADBEEF);
      chk1("hit_no_pre", Precharge, 1'b0);
      chk1("hit_no_act", Activate, 1'b0);
      req_col = 6'd1;
      tick();
      req_valid = 1'b0;
      chk1("hit_r1_rsp", rsp_valid, 1'b1);
      chk32("hit_r1_rdata", rsp_rdata, 32'hF0F0F0F0);
      tick();
      chk1("hit_rsp_end", rsp_valid, 1'b0);

      // open miss: row 2 dirty, read row 7 col 5
      CoreOut = {64{32'h12345678}};
      req_valid = 1'b1; req_write = 1'b0; req_row = 8'd7; req_col = 6'd5;
      tick();
      req_valid = 1'b0; req_row = 8'd0;
      chk1("om_pre_n1", Precharge, 1'b1);
      chk256("om_raddr_pre", RowAddress, 256'h4);
      chk32("om_wb_word", RowBufferIn[191:160], 32'hDEADBEEF);
      chk32("om_wb_word0", RowBufferIn[31:0], 32'hF0F0F0F0);
      chk1("om_busy", req_ready, 1'b0);
      tick();
      chk1("om_pre_n2", Precharge, 1'b1);
      tick();
      chk1("om_pre_off", Precharge, 1'b0);
      chk1("om_act_n3", Activate, 1'b1);
      chk256("om_raddr_act", RowAddress, 256'h80);
      tick();
      chk1("om_act_n4", Activate, 1'b1);
      chk1("om_no_rsp", rsp_valid, 1'b0);
      tick();
      chk1("om_rsp", rsp_valid, 1'b1);
      chk32("om_rdata", rsp_rdata, 32'h12345678);
      chk32("om_open_row", 32'(open_row), 32'd7);

      // close_req and req_valid together: close first, then closed-miss write row 9 col 3
      CoreOut = {64{32'hAAAA5555}};
      close_req = 1'b1;
      req_valid = 1'b1; req_write = 1'b1; req_row = 8'd9; req_col = 6'd3; req_wdata = 32'hCAFEF00D;
      #1;
      chk1("cl_ready_low", req_ready, 1'b0);
      tick();
      close_req = 1'b0;
      chk1("cl_pre_n1", Precharge, 1'b1);
      chk256("cl_raddr", RowAddress, 256'h80);
      chk1("cl_no_rsp", rsp_valid, 1'b0);
      tick();
      chk1("cl_pre_n2", Precharge, 1'b1);
      tick();
      chk1("cl_pre_off", Precharge, 1'b0);
      chk1("cl_row_closed", row_open, 1'b0);
      chk256("cl_raddr_zero", RowAddress, 256'h0);
      chk1("cl_ready_back", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      chk1("cw_act", Activate, 1'b1);
      chk1("cw_no_pre", Precharge, 1'b0);
      chk256("cw_raddr", RowAddress, 256'h200);
      tick();
      chk1("cw_act_n2", Activate, 1'b1);
      tick();
      chk1("cw_rsp", rsp_valid, 1'b1);
      chk32("cw_rdata", rsp_rdata, 32'hCAFEF00D);
      chk32("cw_merge_word", RowBufferIn[127:96], 32'hCAFEF00D);
      chk32("cw_core_word", RowBufferIn[95:64], 32'hAAAA5555);
      chk32("cw_open_row", 32'(open_row), 32'd9);

      // close row 9, then close_req with nothing open is ignored
      close_req = 1'b1;
      tick();
      close_req = 1'b0;
      tick(); tick();
      chk1("cl2_row_closed", row_open, 1'b0);
      close_req = 1'b1;
      #1;
      chk1("ign_ready", req_ready, 1'b1);
      tick();
      chk1("ign_no_pre_n1", Precharge, 1'b0);
      tick();
      chk1("ign_no_pre_n2", Precharge, 1'b0);
      chk1("ign_ready_n2", req_ready, 1'b1);
      close_req = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
